// File: rtl/gcd_job_sequencer.sv
// Job sequencer in front of a start/done GCD core: accepts operand pairs one at a time,
// runs the start/done handshake with a timeout, and queues results in a small FWFT FIFO.
module gcd_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       job_valid,
  output logic       job_ready,
  input  logic [7:0] job_x,
  input  logic [7:0] job_y,
  output logic [7:0] gcd_x,
  output logic [7:0] gcd_y,
  output logic       gcd_start,
  input  logic [7:0] gcd_out,
  input  logic       gcd_done,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW + 1)'(DEPTH);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t        state_reg;
  logic [15:0]   cnt_reg;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic       accept;
  logic       zero_op;
  logic       timed_out;
  logic       push;
  logic       pop;
  logic [8:0] push_word;

  // Space is checked at accept, so the single in-flight job can always push its result.
  assign job_ready = !reset && (state_reg == IDLE) && (count_reg < FULL);
  assign accept    = job_valid && job_ready;
  assign zero_op   = (job_x == 8'd0) || (job_y == 8'd0);
  assign timed_out = (cnt_reg == TO_LAST);
  assign busy      = (state_reg != IDLE);

  assign res_valid = (count_reg != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = res_valid ? mem[rd_ptr_reg][7:0] : 8'd0;
  assign res_err   = res_valid ? mem[rd_ptr_reg][8] : 1'b0;

  // Result word is {err, data}; error entries carry data 0.
  always_comb begin
    push      = 1'b0;
    push_word = 9'h100;
    case (state_reg)
      IDLE:    push = accept && zero_op;
      ISSUE: begin
        if (gcd_done) begin
          push      = 1'b1;
          push_word = {1'b0, gcd_out};
        end else if (timed_out) begin
          push = 1'b1;
        end
      end
      default: push = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 16'd0;
      gcd_x     <= 8'd0;
      gcd_y     <= 8'd0;
      gcd_start <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            gcd_x   <= job_x;
            gcd_y   <= job_y;
            cnt_reg <= 16'd0;
            if (!zero_op) begin
              state_reg <= ISSUE;
              gcd_start <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (gcd_done || timed_out) begin
            state_reg <= RELEASE;
            gcd_start <= 1'b0;
            cnt_reg   <= 16'd0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        RELEASE: begin
          if (!gcd_done || timed_out) begin
            state_reg <= IDLE;
            cnt_reg   <= 16'd0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          gcd_start <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
- Initiator side of the GCD_module handshake (x, y, start -> out, done).
- Accepts operand pairs on a valid/ready job port and drives the GCD core one job at a time.
- Holds start until done, then releases and waits for done to clear.
- Buffers results in a small first-word-fall-through result FIFO with its own valid/ready port.
- Sits between the host/stimulus logic and GCD_module.

Parameters:
DEPTH, 4, result FIFO entries (power of 2, >=2)
TIMEOUT, 255, max cycles spent in ISSUE or RELEASE before abort (>=2, fits 16 bits)

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
job_valid  in  1  job offered
job_ready  out  1  job accepted when job_valid & job_ready
job_x  in  8  operand x
job_y  in  8  operand y
gcd_x  out  8  to GCD_module x
gcd_y  out  8  to GCD_module y
gcd_start  out  1  to GCD_module start
gcd_out  in  8  from GCD_module out
gcd_done  in  1  from GCD_module done
res_valid  out  1  FIFO non-empty
res_ready  in  1  consumer pops when res_valid & res_ready
res_data  out  8  head result (gcd value, 0 on error)
res_err  out  1  head result error flag
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, gcd_start=0, gcd_x=gcd_y=0, FIFO empty, res_valid=0, res_data=0, res_err=0, busy=0, timeout counter=0.
- job_ready = !reset & state==IDLE & FIFO count<DEPTH. It is combinational, and it is 0 while reset is high.
- IDLE, on accept:
  - Latch job_x/job_y into gcd_x/gcd_y.
  - If either operand is 0, push {data=0, err=1} next edge and stay IDLE. The GCD core is never started.
  - Otherwise go to ISSUE.
- ISSUE:
  - gcd_start=1. gcd_x/gcd_y stay stable. The counter increments each cycle.
  - When gcd_done=1 is sampled, push {gcd_out, err=0} and go to RELEASE.
  - If the counter reaches TIMEOUT first, push {0, err=1} and go to RELEASE.
- RELEASE:
  - gcd_start=0. The counter restarts at 0.
  - When gcd_done=0 is sampled, go to IDLE.
  - If the counter reaches TIMEOUT, go to IDLE with no extra push.
- gcd_start is registered: it rises 1 cycle after the accept edge.
- The minimum job turnaround is 3 cycles with a 1-cycle GCD core.
- Only one job is in flight. Space is reserved at accept, so a push never overflows and no result is ever dropped.
- FIFO:
  - res_data/res_err show the head combinationally. res_valid = count!=0.
  - A push into an empty FIFO becomes visible the cycle after the push edge; there is no bypass.
  - Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
  - A pop while empty is ignored.
- res_ready is ignored when res_valid=0. FIFO order equals job accept order.
- Reset mid-job:
  - gcd_start drops immediately (async).
  - The in-flight job and all FIFO contents are discarded.
  - After release, job_ready=1 from the first clock edge.

Test Plan:
1. Reset 25 cycles, then job (10,5) with res_ready=1 and the real GCD_module -> gcd_start held until done, then one result res_data=5, res_err=0; busy returns to 0.
2. Back-to-back jobs (48,18), (17,5), (100,75) with res_ready=1 -> results 6, 1, 25 in order; job_ready low during each job; gcd_start deasserted at least 1 cycle between jobs.
3. Jobs (0,7) then (9,0) -> two results {0, err=1}; gcd_start never asserted; each accept costs 1 cycle.
4. TIMEOUT=16 with a stub that holds gcd_done=0, job (8,4) -> gcd_start high exactly 16 cycles, then result {0, err=1}; state returns to IDLE.
5. res_ready=0, offer 5 jobs (6,4) -> 4 accepted with results 2; job_ready stays 0 after the 4th. Set res_ready=1 -> 4 pops in order, then the 5th job is accepted.
6. Assert reset for 1 cycle mid-ISSUE of job (30,12) with 2 results queued -> gcd_start=0 immediately, res_valid=0; new job (30,12) after reset -> result 6.
